// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - registered N-to-1 stream mux, external select or round-robin
//
// Purpose: picks one of CHANNELS valid/ready input streams and moves its word into
// a single output register. mode=0 uses sel as the channel index; mode=1 arbitrates
// round-robin starting from an internal pointer that advances past each granted channel.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_data    CHANNELS*WIDTH, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (at most one bit set)
//   mode       0 = select by sel, 1 = round-robin
//   sel        channel index used in mode 0
//   out_data   registered word
//   out_chan   source channel of out_data
//   out_valid  output register holds a word
//   out_ready  consumer accepts the held word
`timescale 1ns/1ps

module stream_mux_rr #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_chan_q, out_chan_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             load_en;
  logic             cand_vld;
  logic [SEL_W-1:0] cand_idx;
  logic [WIDTH-1:0] cand_data;
  logic             take;

  always_comb begin
    load_en  = ~out_valid_q | out_ready;
    cand_vld = 1'b0;
    cand_idx = '0;

    if (!mode) begin
      // Non-power-of-two channel counts leave some sel codes with no channel.
      cand_idx = sel;
      cand_vld = (int'(sel) < CHANNELS);
    end else begin
      // Rotating priority as two passes: channels at or above ptr first,
      // then the wrapped-around channels below ptr.
      for (int i = 0; i < CHANNELS; i++) begin
        if (!cand_vld && in_valid[i] && (SEL_W'(i) >= ptr_q)) begin
          cand_vld = 1'b1;
          cand_idx = SEL_W'(i);
        end
      end
      for (int i = 0; i < CHANNELS; i++) begin
        if (!cand_vld && in_valid[i] && (SEL_W'(i) < ptr_q)) begin
          cand_vld = 1'b1;
          cand_idx = SEL_W'(i);
        end
      end
    end

    in_ready  = '0;
    cand_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cand_vld && (cand_idx == SEL_W'(i))) begin
        in_ready[i] = load_en & ~rst;
        cand_data   = in_data[i*WIDTH +: WIDTH];
      end
    end

    take = |(in_valid & in_ready);

    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;

    if (take) begin
      out_data_d  = cand_data;
      out_chan_d  = cand_idx;
      out_valid_d = 1'b1;
      if (mode) begin
        // Explicit wrap so CHANNELS need not be a power of two.
        ptr_d = (cand_idx == SEL_W'(CHANNELS - 1)) ? '0 : cand_idx + SEL_W'(1);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised, registered N-to-1 stream multiplexer with valid/ready handshakes on every input channel and on the output. It generalises the team's fixed 4:1 gate-level mux. It supports any channel count and data width, and two selection modes: externally selected and round-robin arbitrated. One output register stage holds the chosen word. The block sits between multiple producer stages and a single shared consumer in the datapath.

## Interface
Parameters:
- WIDTH, 8: data width per channel, ≥1.
- CHANNELS, 4: number of input channels, ≥2 (not required to be a power of two).
- SEL_W, 2: select/pointer width; must equal ceil(log2(CHANNELS)).

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  channel i presents a word.
- in_ready  output  CHANNELS  channel i word accepted this cycle when in_valid[i] & in_ready[i].
- mode  input  1  0 = select by sel, 1 = round-robin.
- sel  input  SEL_W  channel index used in mode 0.
- out_data  output  WIDTH  registered word.
- out_chan  output  SEL_W  source channel of out_data.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accepts; transfer when out_valid & out_ready.

## Operation
- load_en = ~out_valid | out_ready. The output register may accept a new word when it is empty or is being drained in the same cycle.
- Grant, mode 0: the candidate is channel sel. If sel ≥ CHANNELS, there is no candidate.
- Grant, mode 1: the candidate is the first i with in_valid[i] set, scanning ptr, ptr+1, …, CHANNELS-1, 0, …, ptr-1 (wrap modulo CHANNELS). If no channel is valid, there is no candidate.
- in_ready[g] = load_en for the candidate g. All other in_ready bits are 0. in_ready is combinational from load_en, mode, sel, in_valid (mode 1 only) and ptr. It never depends on in_ready.
- Transfer in (in_valid[g] & in_ready[g]):
  - out_data <= word g; out_chan <= g; out_valid <= 1.
  - In mode 1 only: ptr <= (g+1) mod CHANNELS, with wrap at CHANNELS-1 → 0 even when CHANNELS is not a power of two.
- No transfer in and out_valid & out_ready: out_valid <= 0. out_data and out_chan hold their last values.
- No transfer in and ~out_ready: all outputs hold. A held word never changes while out_valid=1 & out_ready=0.
- ptr is unchanged in mode 0 and retained across mode changes.
- A mode or sel change takes effect on the same cycle's grant. It never disturbs a word already in the output register.
- Reset (async, any time, including mid-transfer): out_valid=0, out_data=0, out_chan=0, ptr=0. Any in-flight word is discarded. While rst=1, in_ready is all 0.

## Timing
- Latency: a word accepted on edge N is visible on out_data with out_valid=1 after edge N.
- Throughput: one word per cycle when out_ready stays 1, including simultaneous drain and refill on the same edge.
- Round-robin fairness: with all CHANNELS inputs continuously valid and out_ready=1, each channel is granted exactly once in every CHANNELS consecutive transfers.
- Timing of rst: assertion clears state immediately, with no clock needed. Deassertion takes effect synchronously; the first grant is possible on the first rising edge with rst=0.

## Test plan
- Reset: assert rst mid-stream with out_valid=1. Required: out_valid, out_data, out_chan and ptr all 0 immediately; in_ready=0 while rst=1.
- Mode 0 select: mode=0, sel=2, all four channels valid with data 0x10,0x21,0x32,0x43, out_ready=1. Required: out_data=0x32 and out_chan=2 every cycle; in_ready=4'b0100.
- Mode 0 with sel out of range: CHANNELS=3, sel=3. Required: in_ready=0; out_valid drops to 0 after the held word drains.
- Round-robin, all valid: mode=1, out_ready=1, CHANNELS=4, all channels valid for 8 cycles. Required: out_chan sequence 0,1,2,3,0,1,2,3; 8 transfers with no bubbles.
- Round-robin, sparse inputs with wrap: ptr=3; only channels 1 and 3 valid. Required: grant 3, then 1, then 3; ptr becomes 0, 2, 0.
- Backpressure: out_ready=0 for 5 cycles while inputs stay valid. Required:
  - out_data is stable and in_ready=0 throughout.
  - When out_ready rises, the held word drains and the next word loads on the same edge.
  - No word is lost or duplicated (check by scoreboard).
